// File: rtl/softmax_ram_mp.sv
// softmax_ram_mp
//   Shared on-chip word memory for the softmax datapath. One lane-masked write
//   port and RD_PORTS independent read ports all see a single coherent image.
//   RD_LATENCY=0 gives combinational (async) reads. RD_LATENCY>=1 gives fully
//   pipelined registered reads. RDW_MODE selects old-data (0) or write-first
//   (1) behaviour for a same-edge, same-address read and write.
// Ports
//   clk       : clock, all state on posedge
//   reset     : synchronous, active-high; array contents are not cleared
//   we        : write enable
//   waddr     : write word address
//   wdata     : write word, lane i = [i*DWIDTH +: DWIDTH]
//   wlane_en  : per-lane write mask
//   rd_en     : per-port read request
//   rd_addr   : port p address = [p*AWIDTH +: AWIDTH]
//   rd_data   : port p word    = [p*DWIDTH*LANES +: DWIDTH*LANES]
//   rd_valid  : per-port data-valid strobe
//   oob_err   : sticky flag, set by any out-of-range read or write
//   wr_count  : committed in-range writes, saturating
module softmax_ram_mp #(
  parameter int DWIDTH     = 16,
  parameter int LANES      = 4,
  parameter int AWIDTH     = 10,
  parameter int MEM_SIZE   = 1024,
  parameter int RD_PORTS   = 3,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               we,
  input  logic [AWIDTH-1:0]                  waddr,
  input  logic [DWIDTH*LANES-1:0]            wdata,
  input  logic [LANES-1:0]                   wlane_en,
  input  logic [RD_PORTS-1:0]                rd_en,
  input  logic [RD_PORTS*AWIDTH-1:0]         rd_addr,
  output logic [RD_PORTS*DWIDTH*LANES-1:0]   rd_data,
  output logic [RD_PORTS-1:0]                rd_valid,
  output logic                               oob_err,
  output logic [31:0]                        wr_count
);

  localparam int WW = DWIDTH * LANES;

  if (RD_LATENCY < 0 || RD_LATENCY > 4) begin : g_bad_latency
    $error("softmax_ram_mp: RD_LATENCY must be 0..4");
  end
  if (RD_PORTS < 1) begin : g_bad_ports
    $error("softmax_ram_mp: RD_PORTS must be at least 1");
  end
  if (MEM_SIZE > (1 << AWIDTH)) begin : g_bad_size
    $error("softmax_ram_mp: MEM_SIZE exceeds address space");
  end

  logic [WW-1:0] mem [MEM_SIZE];

  logic                         w_ok;
  logic [RD_PORTS-1:0]          r_ok;
  logic [RD_PORTS-1:0][WW-1:0]  r_word;

  // Per-port read word. Out-of-range reads return zero. In write-first mode a
  // registered read of the address being written sees the merged word.
  always_comb begin
    logic [AWIDTH-1:0] a;
    w_ok   = 32'(waddr) < MEM_SIZE;
    r_ok   = '0;
    r_word = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      a        = rd_addr[p*AWIDTH +: AWIDTH];
      r_ok[p]  = 32'(a) < MEM_SIZE;
      if (r_ok[p]) begin
        r_word[p] = mem[a];
        if (RDW_MODE == 1 && RD_LATENCY > 0 && we && w_ok && waddr == a) begin
          for (int i = 0; i < LANES; i++) begin
            if (wlane_en[i]) r_word[p][i*DWIDTH +: DWIDTH] = wdata[i*DWIDTH +: DWIDTH];
          end
        end
      end
    end
  end

  // Array has no reset so preloaded contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (!reset && we && w_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (wlane_en[i]) mem[waddr][i*DWIDTH +: DWIDTH] <= wdata[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      oob_err  <= 1'b0;
      wr_count <= '0;
    end else begin
      if ((we && !w_ok) || |(rd_en & ~r_ok)) oob_err <= 1'b1;
      if (we && w_ok && wr_count != 32'hFFFF_FFFF) wr_count <= wr_count + 32'd1;
    end
  end

  if (RD_LATENCY == 0) begin : g_async
    always_comb begin
      rd_valid = rd_en;
      rd_data  = '0;
      for (int p = 0; p < RD_PORTS; p++) rd_data[p*WW +: WW] = r_word[p];
    end
  end else begin : g_pipe
    logic [RD_LATENCY-1:0][RD_PORTS-1:0]          vld;
    logic [RD_LATENCY-1:0][RD_PORTS-1:0][WW-1:0]  dat;

    // Data only advances with a valid token, so every stage (and the output)
    // holds the last valid word while idle.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld <= '0;
        dat <= '0;
      end else begin
        vld[0] <= rd_en;
        for (int p = 0; p < RD_PORTS; p++) begin
          if (rd_en[p]) dat[0][p] <= r_word[p];
        end
        for (int k = 1; k < RD_LATENCY; k++) begin
          vld[k] <= vld[k-1];
          for (int p = 0; p < RD_PORTS; p++) begin
            if (vld[k-1][p]) dat[k][p] <= dat[k-1][p];
          end
        end
      end
    end

    assign rd_valid = vld[RD_LATENCY-1];
    assign rd_data  = dat[RD_LATENCY-1];
  end

endmodule

// File: tb/tb_softmax_ram_mp.sv
// Directed bench for softmax_ram_mp. Five instances with different latency,
// read-during-write and size settings share one stimulus bus.
module tb_softmax_ram_mp;
  logic          clk = 1'b0;
  logic          reset;
  logic          we;
  logic [9:0]    waddr;
  logic [63:0]   wdata;
  logic [3:0]    wlane_en;
  logic [2:0]    rd_en;
  logic [29:0]   rd_addr;

  logic [191:0]  d_l0, d_r0, d_r1, d_l2, d_l3;
  logic [2:0]    v_l0, v_r0, v_r1, v_l2, v_l3;
  logic          o_l0, o_r0, o_r1, o_l2, o_l3;
  logic [31:0]   c_l0, c_r0, c_r1, c_l2, c_l3;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] W5     = 64'h0004_0003_0002_0001;
  localparam logic [63:0] W6     = 64'h6666_6666_6666_6666;
  localparam logic [63:0] W6N    = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] W7     = 64'h0004_0003_0002_0001;
  localparam logic [63:0] W7M    = 64'h0004_0003_0002_AAAA;

  always #5 clk = ~clk;

  softmax_ram_mp #(.RD_LATENCY(0)) u_l0 (.clk(clk), .reset(reset), .we(we), .waddr(waddr),
    .wdata(wdata), .wlane_en(wlane_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d_l0), .rd_valid(v_l0), .oob_err(o_l0), .wr_count(c_l0));
  softmax_ram_mp #(.RD_LATENCY(1), .RDW_MODE(0), .MEM_SIZE(1000)) u_r0 (.clk(clk), .reset(reset),
    .we(we), .waddr(waddr), .wdata(wdata), .wlane_en(wlane_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d_r0), .rd_valid(v_r0), .oob_err(o_r0), .wr_count(c_r0));
  softmax_ram_mp #(.RD_LATENCY(1), .RDW_MODE(1)) u_r1 (.clk(clk), .reset(reset), .we(we),
    .waddr(waddr), .wdata(wdata), .wlane_en(wlane_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d_r1), .rd_valid(v_r1), .oob_err(o_r1), .wr_count(c_r1));
  softmax_ram_mp #(.RD_LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .we(we), .waddr(waddr),
    .wdata(wdata), .wlane_en(wlane_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d_l2), .rd_valid(v_l2), .oob_err(o_l2), .wr_count(c_l2));
  softmax_ram_mp #(.RD_LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .we(we), .waddr(waddr),
    .wdata(wdata), .wlane_en(wlane_en), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(d_l3), .rd_valid(v_l3), .oob_err(o_l3), .wr_count(c_l3));

  function automatic logic [63:0] wv(input int a);
    case (a)
      1:       wv = 64'h1111_2222_3333_4444;
      2:       wv = 64'h5555_6666_7777_8888;
      3:       wv = 64'h9999_AAAA_BBBB_CCCC;
      default: wv = 64'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    we    = 1'b0;
    rd_en = 3'b000;
    repeat (n) step();
  endtask

  task automatic wr(input logic [9:0] a, input logic [63:0] d, input logic [3:0] m);
    we = 1'b1; waddr = a; wdata = d; wlane_en = m;
    step();
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++; if (v_l2 !== 3'b000) begin errors++; $display("FAIL reset_valid got %b exp 000", v_l2); end
    checks++; if (d_l3 !== 192'h0) begin errors++; $display("FAIL reset_data got %h exp 0", d_l3); end
    checks++; if (o_r0 !== 1'b0) begin errors++; $display("FAIL reset_oob got %b exp 0", o_r0); end
    checks++; if (c_r1 !== 32'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", c_r1); end
    reset = 1'b0;
  endtask

  task automatic test_preload();
    wr(10'd1, wv(1), 4'hF);
    wr(10'd2, wv(2), 4'hF);
    wr(10'd3, wv(3), 4'hF);
    wr(10'd5, W5, 4'hF);
    wr(10'd6, W6, 4'hF);
    wr(10'd7, W7, 4'hF);
    checks++; if (c_l0 !== 32'd6) begin errors++; $display("FAIL wr_count_l0 got %0d exp 6", c_l0); end
    checks++; if (c_r0 !== 32'd6) begin errors++; $display("FAIL wr_count_r0 got %0d exp 6", c_r0); end
  endtask

  task automatic test_async();
    rd_addr = {10'd5, 10'd6, 10'd5};
    rd_en   = 3'b111;
    we = 1'b1; waddr = 10'd6; wdata = W6N; wlane_en = 4'hF;
    #1;
    checks++; if (d_l0[63:0] !== W5) begin errors++; $display("FAIL async_p0 got %h exp %h", d_l0[63:0], W5); end
    checks++; if (d_l0[191:128] !== W5) begin errors++; $display("FAIL async_p2_same got %h exp %h", d_l0[191:128], W5); end
    checks++; if (v_l0 !== 3'b111) begin errors++; $display("FAIL async_valid got %b exp 111", v_l0); end
    checks++; if (d_l0[127:64] !== W6) begin errors++; $display("FAIL async_pre_write got %h exp %h", d_l0[127:64], W6); end
    step();
    we = 1'b0;
    #1;
    checks++; if (d_l0[127:64] !== W6N) begin errors++; $display("FAIL async_post_write got %h exp %h", d_l0[127:64], W6N); end
    checks++; if (c_l0 !== 32'd7) begin errors++; $display("FAIL async_count got %0d exp 7", c_l0); end
    rd_en = 3'b000;
    #1;
    checks++; if (v_l0 !== 3'b000) begin errors++; $display("FAIL async_valid_off got %b exp 000", v_l0); end
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [63:0] e;
    for (int t = 0; t < 7; t++) begin
      if (t >= 2 && t <= 5) begin
        checks++; if (v_l2 !== 3'b111) begin errors++; $display("FAIL b2b_valid t%0d got %b exp 111", t, v_l2); end
        for (int p = 0; p < 3; p++) begin
          e = wv(((p + t - 2) % 3) + 1);
          checks++;
          if (d_l2[p*64 +: 64] !== e) begin
            errors++; $display("FAIL b2b_data t%0d p%0d got %h exp %h", t, p, d_l2[p*64 +: 64], e);
          end
        end
      end else begin
        checks++; if (v_l2 !== 3'b000) begin errors++; $display("FAIL b2b_idle t%0d got %b exp 000", t, v_l2); end
      end
      if (t <= 3) begin
        rd_addr = {10'(((2 + t) % 3) + 1), 10'(((1 + t) % 3) + 1), 10'((t % 3) + 1)};
        rd_en   = 3'b111;
      end else begin
        rd_en = 3'b000;
      end
      step();
    end
    e = wv(((0 + 3) % 3) + 1);
    checks++; if (d_l2[63:0] !== e) begin errors++; $display("FAIL b2b_hold got %h exp %h", d_l2[63:0], e); end
    idle(4);
  endtask

  task automatic test_rdw();
    rd_addr = {10'd0, 10'd7, 10'd0};
    rd_en   = 3'b010;
    we = 1'b1; waddr = 10'd7; wdata = 64'hFFFF_EEEE_DDDD_AAAA; wlane_en = 4'b0001;
    step();
    we = 1'b0;
    checks++; if (d_r0[127:64] !== W7) begin errors++; $display("FAIL rdw_old got %h exp %h", d_r0[127:64], W7); end
    checks++; if (d_r1[127:64] !== W7M) begin errors++; $display("FAIL rdw_new got %h exp %h", d_r1[127:64], W7M); end
    checks++; if (v_r0 !== 3'b010) begin errors++; $display("FAIL rdw_valid0 got %b exp 010", v_r0); end
    checks++; if (v_r1 !== 3'b010) begin errors++; $display("FAIL rdw_valid1 got %b exp 010", v_r1); end
    step();
    checks++; if (d_r0[127:64] !== W7M) begin errors++; $display("FAIL rdw_next0 got %h exp %h", d_r0[127:64], W7M); end
    checks++; if (d_r1[127:64] !== W7M) begin errors++; $display("FAIL rdw_next1 got %h exp %h", d_r1[127:64], W7M); end
    rd_en = 3'b000;
    step();
    checks++; if (v_r0 !== 3'b000) begin errors++; $display("FAIL rdw_idle got %b exp 000", v_r0); end
    checks++; if (d_r0[127:64] !== W7M) begin errors++; $display("FAIL rdw_hold got %h exp %h", d_r0[127:64], W7M); end
    idle(3);
  endtask

  task automatic test_oob();
    logic [31:0] n_r0, n_l0;
    checks++; if (o_r0 !== 1'b0) begin errors++; $display("FAIL oob_clean got %b exp 0", o_r0); end
    rd_addr = {10'd0, 10'd0, 10'd1010};
    rd_en   = 3'b001;
    step();
    rd_en = 3'b000;
    checks++; if (d_r0[63:0] !== 64'h0) begin errors++; $display("FAIL oob_rdata got %h exp 0", d_r0[63:0]); end
    checks++; if (v_r0 !== 3'b001) begin errors++; $display("FAIL oob_rvalid got %b exp 001", v_r0); end
    checks++; if (o_r0 !== 1'b1) begin errors++; $display("FAIL oob_set got %b exp 1", o_r0); end
    checks++; if (o_l0 !== 1'b0) begin errors++; $display("FAIL oob_inrange got %b exp 0", o_l0); end
    n_r0 = c_r0;
    n_l0 = c_l0;
    wr(10'd1023, 64'hDEAD_BEEF_DEAD_BEEF, 4'hF);
    checks++; if (c_r0 !== n_r0) begin errors++; $display("FAIL oob_wr_drop got %0d exp %0d", c_r0, n_r0); end
    checks++; if (c_l0 !== n_l0 + 32'd1) begin errors++; $display("FAIL oob_wr_legal got %0d exp %0d", c_l0, n_l0 + 32'd1); end
    idle(3);
    checks++; if (o_r0 !== 1'b1) begin errors++; $display("FAIL oob_sticky got %b exp 1", o_r0); end
  endtask

  task automatic test_reset_mid();
    rd_addr = {10'd3, 10'd2, 10'd1};
    rd_en   = 3'b111;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_en = 3'b000;
    checks++; if (c_l3 !== 32'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", c_l3); end
    checks++; if (o_r0 !== 1'b0) begin errors++; $display("FAIL mid_oob got %b exp 0", o_r0); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (v_l3 !== 3'b000) begin errors++; $display("FAIL mid_valid c%0d got %b exp 000", i, v_l3); end
      checks++; if (d_l3 !== 192'h0) begin errors++; $display("FAIL mid_data c%0d got %h exp 0", i, d_l3); end
      step();
    end
    rd_addr = {10'd0, 10'd0, 10'd5};
    rd_en   = 3'b001;
    step();
    rd_en = 3'b000;
    step();
    step();
    checks++; if (v_l3 !== 3'b001) begin errors++; $display("FAIL mid_readback_valid got %b exp 001", v_l3); end
    checks++; if (d_l3[63:0] !== W5) begin errors++; $display("FAIL mid_readback got %h exp %h", d_l3[63:0], W5); end
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; wlane_en = '0;
    rd_en = '0; rd_addr = '0;
    test_reset();
    test_preload();
    test_async();
    test_back_to_back();
    test_rdw();
    test_oob();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
